// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a shared single-port synchronous RAM.
// Build option: define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (dev1 wins ties); default is round-robin.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dev1_req,
    input  logic                  dev1_we,
    input  logic [ADDR_WIDTH-1:0] dev1_addr,
    input  logic [DATA_WIDTH-1:0] dev1_di,
    input  logic                  dev2_req,
    input  logic                  dev2_we,
    input  logic [ADDR_WIDTH-1:0] dev2_addr,
    input  logic [DATA_WIDTH-1:0] dev2_di,
    output logic                  dev1_gnt,
    output logic                  dev2_gnt,
    output logic                  dev1_rvalid,
    output logic                  dev2_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_do
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t                  state_reg, state_next;
    logic                    sel_reg, sel_next;      // 0 = dev1, 1 = dev2
    logic                    mem_en_reg, mem_en_next;
    logic                    mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_di_reg, mem_di_next;
    logic                    gnt1_reg, gnt1_next;
    logic                    gnt2_reg, gnt2_next;
    logic                    rvalid1_reg, rvalid1_next;
    logic                    rvalid2_reg, rvalid2_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic                    busy_reg, busy_next;
    logic                    win2;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign win2 = dev2_req & ~dev1_req;
`else
    logic last_reg, last_next;                       // 0 = dev1 granted last, 1 = dev2
    // On a tie, dev2 wins only if dev1 was the previous winner.
    assign win2 = dev2_req & (~dev1_req | ~last_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_reg <= 1'b1;
        else        last_reg <= last_next;
    end
`endif

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        mem_en_next   = 1'b0;
        mem_we_next   = 1'b0;
        mem_addr_next = mem_addr_reg;
        mem_di_next   = mem_di_reg;
        gnt1_next     = 1'b0;
        gnt2_next     = 1'b0;
        rvalid1_next  = 1'b0;
        rvalid2_next  = 1'b0;
        rdata_next    = rdata_reg;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        last_next     = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (dev1_req || dev2_req) begin
                    sel_next      = win2;
                    mem_en_next   = 1'b1;
                    mem_we_next   = win2 ? dev2_we   : dev1_we;
                    mem_addr_next = win2 ? dev2_addr : dev1_addr;
                    mem_di_next   = win2 ? dev2_di   : dev1_di;
                    gnt1_next     = ~win2;
                    gnt2_next     = win2;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    last_next     = win2;
`endif
                    state_next    = ACCESS;
                end
            end
            ACCESS: begin
                state_next = mem_we_reg ? IDLE : RDATA;
            end
            RDATA: begin
                rdata_next   = mem_do;
                rvalid1_next = ~sel_reg;
                rvalid2_next = sel_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sel_reg      <= 1'b0;
            mem_en_reg   <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_di_reg   <= '0;
            gnt1_reg     <= 1'b0;
            gnt2_reg     <= 1'b0;
            rvalid1_reg  <= 1'b0;
            rvalid2_reg  <= 1'b0;
            rdata_reg    <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            mem_en_reg   <= mem_en_next;
            mem_we_reg   <= mem_we_next;
            mem_addr_reg <= mem_addr_next;
            mem_di_reg   <= mem_di_next;
            gnt1_reg     <= gnt1_next;
            gnt2_reg     <= gnt2_next;
            rvalid1_reg  <= rvalid1_next;
            rvalid2_reg  <= rvalid2_next;
            rdata_reg    <= rdata_next;
            busy_reg     <= busy_next;
        end
    end

    assign dev1_gnt    = gnt1_reg;
    assign dev2_gnt    = gnt2_reg;
    assign dev1_rvalid = rvalid1_reg;
    assign dev2_rvalid = rvalid2_reg;
    assign rdata       = rdata_reg;
    assign busy        = busy_reg;
    assign mem_en      = mem_en_reg;
    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_di      = mem_di_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dev1_req, dev1_we, dev2_req, dev2_we;
    logic [7:0] dev1_addr, dev1_di, dev2_addr, dev2_di;
    logic       dev1_gnt, dev2_gnt, dev1_rvalid, dev2_rvalid, busy, mem_en, mem_we;
    logic [7:0] rdata, mem_addr, mem_di;
    logic [7:0] mem_do = 8'h00;

    int total = 0;
    int bad   = 0;

    // Unwritten locations read back as addr ^ 0x3D so reads have known contents.
    logic [7:0] ram [256];
    logic       written [256] = '{default: 1'b0};
    logic       hit40 = 1'b0;
    logic [2:0] exp_cont [9];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_addr == 8'h40) hit40 <= 1'b1;
            if (mem_we) begin
                ram[mem_addr]     <= mem_di;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_do <= written[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'h3D);
            end
        end
    end

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .dev1_req(dev1_req), .dev1_we(dev1_we), .dev1_addr(dev1_addr), .dev1_di(dev1_di),
        .dev2_req(dev2_req), .dev2_we(dev2_we), .dev2_addr(dev2_addr), .dev2_di(dev2_di),
        .dev1_gnt(dev1_gnt), .dev2_gnt(dev2_gnt),
        .dev1_rvalid(dev1_rvalid), .dev2_rvalid(dev2_rvalid),
        .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do(mem_do)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        // {dev1_gnt, dev2_gnt, dev1_rvalid}: dev1 read repeats every 3 cycles
        exp_cont = '{3'b100, 3'b000, 3'b001, 3'b100, 3'b000, 3'b001, 3'b100, 3'b000, 3'b001};
`else
        // dev1 read (3 cycles) alternates with dev2 write (2 cycles)
        exp_cont = '{3'b100, 3'b000, 3'b001, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b010};
`endif
        // Reset held with both devices requesting
        rst_n = 1'b0;
        dev1_req = 1'b1; dev1_we = 1'b1; dev1_addr = 8'h10; dev1_di = 8'hA5;
        dev2_req = 1'b1; dev2_we = 1'b1; dev2_addr = 8'h20; dev2_di = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_gnt_%0d", i), {dev1_gnt, dev2_gnt}, 2'b00);
            chk($sformatf("rst_busy_%0d", i), busy, 1'b0);
            chk($sformatf("rst_en_we_%0d", i), {mem_en, mem_we}, 2'b00);
        end
        chk("rst_addr_di", {mem_addr, mem_di}, 16'h0000);
        chk("rst_rdata_rvalid", {rdata, dev1_rvalid, dev2_rvalid}, 10'h000);

        // First tie after reset goes to dev1 (write 0x10 <= 0xA5)
        rst_n = 1'b1;
        tick();
        chk("first_gnt", {dev1_gnt, dev2_gnt}, 2'b10);
        chk("first_en_we", {mem_en, mem_we}, 2'b11);
        chk("first_addr_di", {mem_addr, mem_di}, 16'h10A5);
        chk("first_busy", busy, 1'b1);
        dev1_req = 1'b0; dev2_req = 1'b0;
        tick();
        chk("wr_done_busy", busy, 1'b0);
        chk("wr_done_en", mem_en, 1'b0);
        chk("wr_hold_addr", mem_addr, 8'h10);

        // dev1 reads 0x10 back
        dev1_req = 1'b1; dev1_we = 1'b0;
        tick();
        chk("rd_gnt", {dev1_gnt, dev2_gnt}, 2'b10);
        chk("rd_en_we", {mem_en, mem_we}, 2'b10);
        dev1_req = 1'b0;
        tick();
        chk("rd_rdata_state", {dev1_gnt, busy, dev1_rvalid}, 3'b010);
        tick();
        chk("rd_rvalid", {dev1_rvalid, dev2_rvalid}, 2'b10);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_busy", busy, 1'b0);
        tick();
        chk("rd_rvalid_pulse", dev1_rvalid, 1'b0);
        chk("rd_rdata_hold", rdata, 8'hA5);

        // Contention: fresh reset, dev1 reads 0x01, dev2 writes 0x02 <= 0x77
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dev1_req = 1'b1; dev1_we = 1'b0; dev1_addr = 8'h01;
        dev2_req = 1'b1; dev2_we = 1'b1; dev2_addr = 8'h02; dev2_di = 8'h77;
        for (int c = 0; c < 9; c++) begin
            tick();
            chk($sformatf("cont_c%0d", c + 1), {dev1_gnt, dev2_gnt, dev1_rvalid}, exp_cont[c]);
        end
        dev1_req = 1'b0; dev2_req = 1'b0;
        tick();
        tick();
        chk("cont_rdata", rdata, 8'h3C);
        chk("cont_idle", busy, 1'b0);
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        chk("cont_ram2", ram[2], 8'h77);
`endif

        // Withdrawal: dev2 requests only during dev1's ACCESS
        dev1_req = 1'b1; dev1_we = 1'b1; dev1_addr = 8'h30; dev1_di = 8'h11;
        tick();
        chk("wd_gnt1", {dev1_gnt, dev2_gnt}, 2'b10);
        dev1_req = 1'b0;
        dev2_req = 1'b1; dev2_we = 1'b1; dev2_addr = 8'h40; dev2_di = 8'h99;
        tick();
        dev2_req = 1'b0;
        chk("wd_idle", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wd_no_gnt2_%0d", i), {dev2_gnt, mem_en}, 2'b00);
        end
        chk("wd_no_access40", hit40, 1'b0);
        chk("wd_ram30", ram[8'h30], 8'h11);

        // Mid-read reset during RDATA of a dev2 read
        dev2_req = 1'b1; dev2_we = 1'b0; dev2_addr = 8'h02;
        tick();
        chk("mr_gnt2", {dev1_gnt, dev2_gnt}, 2'b01);
        dev2_req = 1'b0;
        tick();
        chk("mr_in_rdata", {busy, dev2_rvalid}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mr_async_clear", {rdata, busy, mem_en}, 10'h000);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mr_no_rvalid", {dev1_rvalid, dev2_rvalid}, 2'b00);
        chk("mr_rdata_zero", rdata, 8'h00);
        chk("mr_idle", busy, 1'b0);
        dev2_req = 1'b1;
        tick();
        chk("mr_next_gnt2", {dev1_gnt, dev2_gnt}, 2'b01);
        dev2_req = 1'b0;
        tick();
        tick();
        chk("mr_next_rvalid", {dev1_rvalid, dev2_rvalid}, 2'b01);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        chk("mr_next_rdata", rdata, 8'h3F);
`else
        chk("mr_next_rdata", rdata, 8'h77);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-requester arbiter and sequencer for the shared single-port synchronous RAM.
- Accepts independent request/grant handshakes from device 1 and device 2 and issues one RAM access at a time.
- Returns read data with a per-device valid strobe.
- Sits between the bus-mastering devices and the `ram` instance; it drives every RAM port.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 8, RAM data width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- dev1_req / dev2_req  in  1  access request; held until the matching gnt pulse
- dev1_we / dev2_we  in  1  1 = write, 0 = read; stable while req is high
- dev1_addr / dev2_addr  in  ADDR_WIDTH  access address; stable while req is high
- dev1_di / dev2_di  in  DATA_WIDTH  write data; stable while req is high
- dev1_gnt / dev2_gnt  out  1  one-cycle pulse: the access is being issued to RAM this cycle
- dev1_rvalid / dev2_rvalid  out  1  one-cycle pulse: rdata holds this device's read result
- rdata  out  DATA_WIDTH  captured read data, shared by both devices
- busy  out  1  high in any state other than IDLE
- mem_en, mem_we  out  1  RAM enable and write enable (registered)
- mem_addr  out  ADDR_WIDTH  RAM address (registered)
- mem_di  out  DATA_WIDTH  RAM write data (registered)
- mem_do  in  DATA_WIDTH  RAM read data; valid the cycle after the enabled read edge

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- **IDLE**
  - No req high: stay in IDLE.
  - Any req high: select a winner, load mem_addr/mem_di/mem_we from the winner, set mem_en, go to ACCESS.
  - Record the winner in the `sel` flop.
- **ACCESS** (exactly one cycle)
  - mem_en=1; gnt of `sel` = 1.
  - Write: next state IDLE.
  - Read: next state RDATA.
  - mem_en and mem_we clear on exit.
- **RDATA** (one cycle)
  - mem_do is valid.
  - At the end of the cycle: rdata <= mem_do, rvalid of `sel` is set for the next cycle, next state IDLE.
- **Arbitration**
  - Round-robin using a `last` flop, updated on every grant.
  - Both requesting: grant the device not in `last`.
  - One requesting: grant it regardless of `last`.
- **Request withdrawal**
  - A device may drop req before it is granted; it then takes no part in arbitration.
  - Req is sampled only in IDLE.
  - Once the FSM leaves IDLE, the sampled access completes even if req drops.
- **Outputs when not issuing**
  - mem_addr and mem_di hold their last values when not in ACCESS.
  - mem_en and mem_we are 0 outside ACCESS.
- **Reset (rst_n low, any time including mid-access)**
  - Every output goes to 0: gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_di.
  - state = IDLE; `last` = device 2, so device 1 wins the first tie.
  - An in-flight read is dropped with no rvalid.

## Timing
- Cycle numbering: req is first seen high in IDLE during cycle k.
- Write: gnt and mem_en high in cycle k+1; the RAM writes at the end of k+1; busy is low again in k+2.
  - Back-to-back write throughput is one access per 2 cycles.
- Read: gnt in k+1, RDATA in k+2, rvalid and rdata valid in k+3.
  - k+3 is also an IDLE cycle, so a new request can be sampled there.
  - Read throughput is one access per 3 cycles.
- rvalid of a read is never asserted in the same cycle as gnt of that read.
- A requester that holds req after its gnt pulse issues a new request, sampled at the next IDLE cycle.
- busy = (state != IDLE), registered.

## Configuration
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, device 1 always wins a tie; `last` is not implemented.
- Undefined (default): round-robin as described under Operation.

## Test plan
- Reset: assert rst_n=0 for 3 cycles with both req high -> all outputs 0, no gnt during reset; first grant after release goes to dev1.
- Single write then read: dev1 writes addr 0x10, data 0xA5, then reads 0x10 -> dev1_gnt 1 cycle after each request; dev1_rvalid=1 with rdata=0xA5 three cycles after the read request is sampled.
- Contention: both req held high, dev1 reads addr 0x01, dev2 writes 0x02 -> grants alternate dev1, dev2, dev1, dev2; with MEM_ARB_FIXED_PRIORITY_EN defined, dev1 is granted every time.
- Withdrawal: dev2 raises req during dev1's ACCESS and drops it before IDLE -> no dev2_gnt, no RAM access to dev2_addr.
- Mid-read reset: pulse rst_n low during RDATA of a dev2 read -> no dev2_rvalid; rdata=0; FSM in IDLE; next access proceeds normally.
